// File: rtl/grill_scheduler.sv
// grill_scheduler: four-slot steak grill driven by two players' commands and a
// shared game tick. Each slot runs its own small FSM (grill_slot). The top
// level arbitrates between the players, routes the winning command to one slot,
// and registers the acks, event pulses and score.
// Optional feature: define GRILL_AUTO_CLEAR_EN so that a BURNT slot clears
// itself to EMPTY after CLEAR_TICKS ticks. Without it, a BURNT slot stays BURNT
// until it is served.

package grill_pkg;
  typedef enum logic [2:0] {
    S_EMPTY      = 3'd0,
    S_SIDE_A     = 3'd1,
    S_FLIP_READY = 3'd2,
    S_SIDE_B     = 3'd3,
    S_DONE       = 3'd4,
    S_BURNT      = 3'd5
  } slot_t;

  localparam logic [1:0] OP_PLACE = 2'b01;
  localparam logic [1:0] OP_FLIP  = 2'b10;
  localparam logic [1:0] OP_SERVE = 2'b11;
endpackage

// One grill slot: a state register plus an 8-bit tick counter. A command always
// takes precedence over a tick in the same cycle, so the tick is simply ignored
// for a slot that is being commanded.
module grill_slot
  import grill_pkg::*;
#(
  parameter int COOK_TICKS  = 8,
  parameter int BURN_TICKS  = 4,
  parameter int CLEAR_TICKS = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic       cmd,
  input  logic [1:0] op,
  output logic [2:0] state,
  output logic       burn_ev,
  output logic       serve_ev,
  output logic       err_ev
);

`ifdef GRILL_AUTO_CLEAR_EN
  localparam bit AUTO_CLR = 1'b1;
`else
  localparam bit AUTO_CLR = 1'b0;
`endif

  localparam logic [7:0] COOK_LAST  = 8'(COOK_TICKS - 1);
  localparam logic [7:0] BURN_LAST  = 8'(BURN_TICKS - 1);
  localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_TICKS - 1);

  slot_t      st, st_nxt;
  logic [7:0] cnt, cnt_nxt;

  assign state = st;

  // Slot state and tick counter register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st  <= S_EMPTY;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  // Next state: a command is handled first, otherwise a tick advances the
  // timers. Any state change restarts the counter from zero.
  always_comb begin
    st_nxt   = st;
    cnt_nxt  = cnt;
    burn_ev  = 1'b0;
    serve_ev = 1'b0;
    err_ev   = 1'b0;
    if (cmd) begin
      if (op == OP_PLACE && st == S_EMPTY)
        st_nxt = S_SIDE_A;
      else if (op == OP_FLIP && st == S_FLIP_READY)
        st_nxt = S_SIDE_B;
      else if (op == OP_SERVE && st == S_DONE) begin
        st_nxt   = S_EMPTY;
        serve_ev = 1'b1;
      end else if (op == OP_SERVE && st == S_BURNT)
        st_nxt = S_EMPTY;
      else
        err_ev = 1'b1;
    end else if (tick) begin
      case (st)
        S_SIDE_A: begin
          if (cnt == COOK_LAST) st_nxt = S_FLIP_READY;
          else                  cnt_nxt = cnt + 8'd1;
        end
        S_SIDE_B: begin
          if (cnt == COOK_LAST) st_nxt = S_DONE;
          else                  cnt_nxt = cnt + 8'd1;
        end
        S_FLIP_READY, S_DONE: begin
          if (cnt == BURN_LAST) begin
            st_nxt  = S_BURNT;
            burn_ev = 1'b1;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        S_BURNT: begin
          // Without auto-clear the slot waits for SERVE; the counter stays put.
          if (AUTO_CLR) begin
            if (cnt == CLEAR_LAST) st_nxt = S_EMPTY;
            else                   cnt_nxt = cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
    if (st_nxt != st) cnt_nxt = '0;
  end

endmodule

// Top level: two-player round-robin arbiter feeding four grill slots.
module grill_scheduler
  import grill_pkg::*;
#(
  parameter int COOK_TICKS  = 8,
  parameter int BURN_TICKS  = 4,
  parameter int CLEAR_TICKS = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tick,
  input  logic        p0_valid,
  input  logic [1:0]  p0_slot,
  input  logic [1:0]  p0_op,
  input  logic        p1_valid,
  input  logic [1:0]  p1_slot,
  input  logic [1:0]  p1_op,
  output logic        p0_ack,
  output logic        p1_ack,
  output logic [11:0] slot_state,
  output logic [7:0]  score,
  output logic        serve_pulse,
  output logic        burn_pulse,
  output logic        err_pulse
);

  localparam int NUM_SLOTS = 4;

  logic                      elig0, elig1, gnt0, gnt1, gnt_any;
  logic                      prio;  // 0: player 0 wins a tie, 1: player 1 wins
  logic [1:0]                gnt_slot, gnt_op;
  logic [NUM_SLOTS-1:0]      slot_cmd, burn_ev, serve_ev, err_ev;
  logic [NUM_SLOTS-1:0][2:0] st;
  logic [7:0]                score_nxt;

  // Arbitration: a player whose ack is currently high has just been served and
  // is still holding valid, so it sits out this cycle.
  always_comb begin
    elig0    = p0_valid & ~p0_ack;
    elig1    = p1_valid & ~p1_ack;
    gnt0     = elig0 & (~elig1 | ~prio);
    gnt1     = elig1 & (~elig0 |  prio);
    gnt_any  = gnt0 | gnt1;
    gnt_slot = gnt0 ? p0_slot : p1_slot;
    gnt_op   = gnt0 ? p0_op   : p1_op;
  end

  // Score increments on a served steak and sticks at 255
  always_comb begin
    score_nxt = score;
    if (|serve_ev && score != 8'hFF) score_nxt = score + 8'd1;
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_lane
    assign slot_cmd[i] = gnt_any && (gnt_slot == 2'(i));

    grill_slot #(
      .COOK_TICKS  (COOK_TICKS),
      .BURN_TICKS  (BURN_TICKS),
      .CLEAR_TICKS (CLEAR_TICKS)
    ) u_slot (
      .clk      (clk),
      .resetn   (resetn),
      .tick     (tick),
      .cmd      (slot_cmd[i]),
      .op       (gnt_op),
      .state    (st[i]),
      .burn_ev  (burn_ev[i]),
      .serve_ev (serve_ev[i]),
      .err_ev   (err_ev[i])
    );
  end

  assign slot_state = st;

  // Acks, event pulses, score and round-robin priority
  always_ff @(posedge clk) begin
    if (!resetn) begin
      p0_ack      <= 1'b0;
      p1_ack      <= 1'b0;
      serve_pulse <= 1'b0;
      burn_pulse  <= 1'b0;
      err_pulse   <= 1'b0;
      score       <= '0;
      prio        <= 1'b0;
    end else begin
      p0_ack      <= gnt0;
      p1_ack      <= gnt1;
      serve_pulse <= |serve_ev;
      burn_pulse  <= |burn_ev;
      err_pulse   <= |err_ev;
      score       <= score_nxt;
      if (gnt_any) prio <= gnt0;
    end
  end

endmodule
